// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter for two write clients and one read client in front
// of the single-port BRAM controller; one transaction in flight at a time.
module mem_req_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr0_req_i,
   input  logic [ADDR_W-1:0] wr0_addr_i,
   input  logic [DATA_W-1:0] wr0_data_i,
   output logic              wr0_ack_o,
   input  logic              wr1_req_i,
   input  logic [ADDR_W-1:0] wr1_addr_i,
   input  logic [DATA_W-1:0] wr1_data_i,
   output logic              wr1_ack_o,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic              rd_ack_o,
   output logic              rd_valid_o,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic              ctrl_ready_i,
   output logic              ctrl_read_en_o,
   output logic [1:0]        ctrl_write_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_ACCESS,
      S_RDATA
   } state_t;

   state_t     state;
   logic [1:0] ptr;
   logic       is_rd;
   logic [2:0] req;
   logic [2:0] gnt;

   assign req = {rd_req_i, wr1_req_i, wr0_req_i};

   // ptr names the client with highest priority: 0=wr0, 1=wr1, 2=rd
   always_comb begin
      gnt = 3'b000;
      if (state == S_IDLE) begin
         case (ptr)
            2'd0: begin
               gnt[0] = req[0];
               gnt[1] = ~req[0] & req[1];
               gnt[2] = ~req[0] & ~req[1] & req[2];
            end
            2'd1: begin
               gnt[1] = req[1];
               gnt[2] = ~req[1] & req[2];
               gnt[0] = ~req[1] & ~req[2] & req[0];
            end
            default: begin
               gnt[2] = req[2];
               gnt[0] = ~req[2] & req[0];
               gnt[1] = ~req[2] & ~req[0] & req[1];
            end
         endcase
      end
   end

   assign wr0_ack_o = gnt[0];
   assign wr1_ack_o = gnt[1];
   assign rd_ack_o  = gnt[2];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state           <= S_IDLE;
         ptr             <= 2'd0;
         is_rd           <= 1'b0;
         ctrl_read_en_o  <= 1'b0;
         ctrl_write_en_o <= 2'b00;
         mem_addr_o      <= '0;
         mem_wdata_o     <= '0;
         rd_data_o       <= '0;
         rd_valid_o      <= 1'b0;
      end else begin
         rd_valid_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|gnt) begin
                  state <= S_ISSUE;
                  is_rd <= gnt[2];
                  unique case (1'b1)
                     gnt[2]: begin
                        mem_addr_o     <= rd_addr_i;
                        ctrl_read_en_o <= 1'b1;
                        ptr            <= 2'd0;
                     end
                     gnt[1]: begin
                        mem_addr_o      <= wr1_addr_i;
                        mem_wdata_o     <= wr1_data_i;
                        ctrl_write_en_o <= 2'b10;
                        ptr             <= 2'd2;
                     end
                     gnt[0]: begin
                        mem_addr_o      <= wr0_addr_i;
                        mem_wdata_o     <= wr0_data_i;
                        ctrl_write_en_o <= 2'b01;
                        ptr             <= 2'd1;
                     end
                  endcase
               end
            end
            S_ISSUE: begin
               if (ctrl_ready_i) begin
                  ctrl_read_en_o  <= 1'b0;
                  ctrl_write_en_o <= 2'b00;
                  state           <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               state <= is_rd ? S_RDATA : S_IDLE;
            end
            S_RDATA: begin
               rd_data_o  <= mem_rdata_i;
               rd_valid_o <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a controller/BRAM model:
// vector table for single transactions plus hand-written corner sequences.
module tb_mem_req_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr0_req, wr1_req, rd_req;
   logic [9:0] wr0_addr, wr1_addr, rd_addr;
   logic [7:0] wr0_data, wr1_data;
   logic       wr0_ack, wr1_ack, rd_ack;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       ready;
   logic       re;
   logic [1:0] we;
   logic [9:0] maddr;
   logic [7:0] mwdata;
   logic [7:0] mrdata;

   int passed = 0;
   int total  = 0;
   int viol   = 0;

   always #5 clk = ~clk;

   mem_req_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .wr0_req_i(wr0_req), .wr0_addr_i(wr0_addr),
      .wr0_data_i(wr0_data), .wr0_ack_o(wr0_ack),
      .wr1_req_i(wr1_req), .wr1_addr_i(wr1_addr),
      .wr1_data_i(wr1_data), .wr1_ack_o(wr1_ack),
      .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack),
      .rd_valid_o(rd_valid), .rd_data_o(rd_data),
      .ctrl_ready_i(ready), .ctrl_read_en_o(re),
      .ctrl_write_en_o(we), .mem_addr_o(maddr),
      .mem_wdata_o(mwdata), .mem_rdata_i(mrdata)
   );

   // controller + BRAM: enable accepted with ready -> access next cycle
   logic       acc = 1'b0;
   logic       acc_wr = 1'b0;
   logic [7:0] mem [0:1023];

   always @(posedge clk) begin
      acc    <= (re | (|we)) & ready;
      acc_wr <= |we;
      if (acc) begin
         if (acc_wr) mem[maddr] <= mwdata;
         else mrdata <= mem[maddr];
      end
   end

   always @(negedge clk)
      if ((re && we != 2'b00) || we == 2'b11) viol++;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] acks();
      return {rd_ack, wr1_ack, wr0_ack};
   endfunction

   task automatic clear_req();
      wr0_req = 0;
      wr1_req = 0;
      rd_req  = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      step();
      rst = 0;
   endtask

   typedef struct {
      logic       r0, r1, rr;
      logic [9:0] a0, a1, ra;
      logic [7:0] d0, d1;
      logic [2:0] ack;
      logic [1:0] we;
      logic       re;
      logic [9:0] addr;
      logic [7:0] wdata, rdata;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [2:0] cexp [14];
      logic       seen;

      vecs[0] = '{1,0,0, 10'h005,10'h000,10'h000, 8'hA5,8'h00,
                  3'b001,2'b01,0, 10'h005,8'hA5,8'h00};
      vecs[1] = '{1,0,0, 10'h010,10'h000,10'h000, 8'h3C,8'h00,
                  3'b001,2'b01,0, 10'h010,8'h3C,8'h00};
      vecs[2] = '{0,0,1, 10'h000,10'h000,10'h010, 8'h00,8'h00,
                  3'b100,2'b00,1, 10'h010,8'h00,8'h3C};
      vecs[3] = '{1,1,0, 10'h020,10'h3FF,10'h000, 8'h11,8'h5A,
                  3'b001,2'b01,0, 10'h020,8'h11,8'h00};
      vecs[4] = '{1,1,1, 10'h021,10'h3FF,10'h005, 8'h22,8'h5A,
                  3'b010,2'b10,0, 10'h3FF,8'h5A,8'h00};
      vecs[5] = '{1,0,1, 10'h030,10'h000,10'h3FF, 8'h77,8'h00,
                  3'b100,2'b00,1, 10'h3FF,8'h00,8'h5A};
      vecs[6] = '{0,1,1, 10'h000,10'h100,10'h005, 8'h00,8'hC3,
                  3'b010,2'b10,0, 10'h100,8'hC3,8'h00};
      vecs[7] = '{1,0,1, 10'h040,10'h000,10'h020, 8'h99,8'h00,
                  3'b100,2'b00,1, 10'h020,8'h00,8'h11};
      vecs[8] = '{0,0,1, 10'h000,10'h000,10'h100, 8'h00,8'h00,
                  3'b100,2'b00,1, 10'h100,8'h00,8'hC3};

      rst = 1;
      ready = 1;
      clear_req();
      wr0_addr = 0; wr1_addr = 0; rd_addr = 0;
      wr0_data = 0; wr1_data = 0;

      #2;
      check("rst_acks", acks(), 3'b000);
      check("rst_valid", rd_valid, 0);
      check("rst_re", re, 0);
      check("rst_we", we, 0);
      check("rst_addr", maddr, 0);
      check("rst_wdata", mwdata, 0);
      check("rst_rdata", rd_data, 0);
      @(posedge clk);
      step();
      rst = 0;

      // single transactions; rr pointer carries across records
      for (int i = 0; i < 9; i++) begin
         wr0_req = vecs[i].r0; wr0_addr = vecs[i].a0;
         wr0_data = vecs[i].d0;
         wr1_req = vecs[i].r1; wr1_addr = vecs[i].a1;
         wr1_data = vecs[i].d1;
         rd_req = vecs[i].rr; rd_addr = vecs[i].ra;
         #1;
         check($sformatf("v%0d_ack", i), acks(), vecs[i].ack);
         step();
         clear_req();
         #1;
         check($sformatf("v%0d_t1_ack", i), acks(), 3'b000);
         check($sformatf("v%0d_we", i), we, vecs[i].we);
         check($sformatf("v%0d_re", i), re, vecs[i].re);
         check($sformatf("v%0d_addr", i), maddr, vecs[i].addr);
         check($sformatf("v%0d_t1_valid", i), rd_valid, 0);
         if (!vecs[i].re)
            check($sformatf("v%0d_wdata", i), mwdata, vecs[i].wdata);
         step();
         check($sformatf("v%0d_t2_en", i), {re, we}, 3'b000);
         check($sformatf("v%0d_t2_addr", i), maddr, vecs[i].addr);
         step();
         if (vecs[i].re) begin
            check($sformatf("v%0d_t3_valid", i), rd_valid, 0);
            step();
            check($sformatf("v%0d_valid", i), rd_valid, 1);
            check($sformatf("v%0d_rdata", i), rd_data, vecs[i].rdata);
         end
      end

      // contention: all three held high from reset
      step();
      do_reset();
      wr0_addr = 10'h050; wr0_data = 8'h01;
      wr1_addr = 10'h051; wr1_data = 8'h02;
      rd_addr  = 10'h005;
      wr0_req = 1; wr1_req = 1; rd_req = 1;
      foreach (cexp[k]) cexp[k] = 3'b000;
      cexp[0] = 3'b001; cexp[3] = 3'b010;
      cexp[6] = 3'b100; cexp[10] = 3'b001;
      for (int c = 0; c < 11; c++) begin
         #1;
         check($sformatf("cont_c%0d_ack", c), acks(), cexp[c]);
         if (c == 1) check("cont_we0", we, 2'b01);
         if (c == 4) check("cont_we1", we, 2'b10);
         if (c == 7) check("cont_re", re, 1);
         if (c == 10) begin
            check("cont_valid", rd_valid, 1);
            check("cont_rdata", rd_data, 8'hA5);
         end
         step();
      end
      clear_req();
      step();
      step();

      // ready stall: write held in issue while ready is low
      do_reset();
      ready = 0;
      wr1_addr = 10'h123; wr1_data = 8'h4E;
      wr0_addr = 10'h124; wr0_data = 8'h6B;
      wr1_req = 1;
      #1;
      check("stall_ack", acks(), 3'b010);
      step();
      wr1_req = 0;
      wr0_req = 1;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) ready = 1;
         #1;
         check($sformatf("stall_c%0d_we", c), we, 2'b10);
         check($sformatf("stall_c%0d_ack", c), acks(), 3'b000);
         check($sformatf("stall_c%0d_addr", c), maddr, 10'h123);
         check($sformatf("stall_c%0d_wd", c), mwdata, 8'h4E);
         step();
      end
      #1;
      check("stall_acc_we", we, 2'b00);
      check("stall_acc_ack", acks(), 3'b000);
      step();
      #1;
      check("stall_next_ack", acks(), 3'b001);
      step();
      clear_req();
      step();
      step();

      // reset restores wr0 as highest priority (pointer was at wr1)
      do_reset();
      wr0_addr = 10'h300; wr1_addr = 10'h301;
      wr0_req = 1; wr1_req = 1;
      #1;
      check("rstprio_ack", acks(), 3'b001);
      step();
      clear_req();
      step();
      step();

      // reset while the read is in its access cycle
      rd_addr = 10'h010;
      rd_req = 1;
      #1;
      check("midrd_ack", acks(), 3'b100);
      step();
      clear_req();
      step();
      rst = 1;
      #1;
      check("midrd_re", re, 0);
      check("midrd_we", we, 0);
      check("midrd_addr", maddr, 0);
      check("midrd_wdata", mwdata, 0);
      check("midrd_rdata", rd_data, 0);
      check("midrd_valid", rd_valid, 0);
      step();
      step();
      rst = 0;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (rd_valid) seen = 1;
         step();
      end
      check("midrd_no_valid", seen, 0);
      rd_req = 1;
      #1;
      check("midrd_regrant", acks(), 3'b100);
      step();
      clear_req();
      step();
      step();
      step();
      check("midrd_valid2", rd_valid, 1);
      check("midrd_rdata2", rd_data, 8'h3C);

      // wr1 pulsed for one cycle while busy: withdrawn
      wr0_addr = 10'h200; wr0_data = 8'hEE;
      wr1_addr = 10'h010; wr1_data = 8'hFF;
      wr0_req = 1;
      #1;
      check("wd_ack0", acks(), 3'b001);
      step();
      wr0_req = 0;
      wr1_req = 1;
      #1;
      check("wd_busy_ack", acks(), 3'b000);
      step();
      wr1_req = 0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (wr1_ack || we == 2'b10) seen = 1;
         step();
      end
      check("wd_no_wr1", seen, 0);
      rd_addr = 10'h010;
      rd_req = 1;
      #1;
      check("wd_rd_ack", acks(), 3'b100);
      step();
      clear_req();
      step();
      step();
      step();
      check("wd_valid", rd_valid, 1);
      check("wd_rdata", rd_data, 8'h3C);
      step();
      check("wd_valid_drop", rd_valid, 0);

      check("enable_invariant", viol, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
